// File: rtl/regfile_cmd_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | regfile_cmd_ctrl_if: byte command link, register file and response bus |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
interface regfile_cmd_ctrl_if #(
  parameter int WIDTH   = 8,
  parameter int ADDRESS = 4
) ();
  logic               RX_Valid;
  logic [WIDTH-1:0]   RX_Data;
  logic               WrEn;
  logic               RdEn;
  logic [ADDRESS-1:0] Address;
  logic [WIDTH-1:0]   WrData;
  logic [WIDTH-1:0]   RdData;
  logic               RdData_Valid;
  logic [WIDTH-1:0]   TX_Data;
  logic               TX_Valid;
  logic               TX_Ready;
  logic               Busy;
  logic               Overrun;

  // Controller side
  modport master (
    input  RX_Valid, RX_Data, RdData, RdData_Valid, TX_Ready,
    output WrEn, RdEn, Address, WrData, TX_Data, TX_Valid, Busy, Overrun
  );

  // Byte source, register file and response consumer side
  modport slave (
    output RX_Valid, RX_Data, RdData, RdData_Valid, TX_Ready,
    input  WrEn, RdEn, Address, WrData, TX_Data, TX_Valid, Busy, Overrun
  );
endinterface
`default_nettype wire

// File: rtl/regfile_cmd_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | regfile_cmd_ctrl: byte-command decoder driving a register file port     |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module regfile_cmd_ctrl #(
  parameter int               WIDTH    = 8,
  parameter int               ADDRESS  = 4,
  parameter int               TIMEOUT  = 15,
  parameter logic [WIDTH-1:0] WR_CMD   = 8'hAA,
  parameter logic [WIDTH-1:0] RD_CMD   = 8'hBB,
  parameter logic [WIDTH-1:0] ERR_CODE = 8'hEE
) (
  input logic                CLK,
  input logic                RST,
  regfile_cmd_ctrl_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               wr_en, wr_en_next;
  logic               rd_en, rd_en_next;
  logic [ADDRESS-1:0] addr, addr_next;
  logic [WIDTH-1:0]   wr_data, wr_data_next;
  logic [WIDTH-1:0]   tx_data, tx_data_next;
  logic               tx_valid, tx_valid_next;
  logic               busy, busy_next;
  logic               overrun, overrun_next;
  logic               addr_bad;

  // Any operand bit beyond the address range aborts the command
  assign addr_bad = (bus.RX_Data >> ADDRESS) != '0;

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    wr_en_next    = 1'b0;
    rd_en_next    = 1'b0;
    addr_next     = addr;
    wr_data_next  = wr_data;
    tx_data_next  = tx_data;
    tx_valid_next = tx_valid;
    overrun_next  = overrun;
    case (state)
      IDLE: begin
        if (bus.RX_Valid) begin
          if (bus.RX_Data == WR_CMD)      state_next = WR_ADDR;
          else if (bus.RX_Data == RD_CMD) state_next = RD_ADDR;
        end
      end
      WR_ADDR, RD_ADDR: begin
        if (bus.RX_Valid) begin
          if (addr_bad) begin
            tx_data_next  = ERR_CODE;
            tx_valid_next = 1'b1;
            state_next    = TX_SEND;
          end else begin
            addr_next = bus.RX_Data[ADDRESS-1:0];
            if (state == WR_ADDR) begin
              state_next = WR_DATA;
            end else begin
              rd_en_next = 1'b1;
              cnt_next   = '0;
              state_next = RD_WAIT;
            end
          end
        end
      end
      WR_DATA: begin
        if (bus.RX_Valid) begin
          wr_data_next = bus.RX_Data;
          wr_en_next   = 1'b1;
          state_next   = IDLE;
        end
      end
      RD_WAIT: begin
        overrun_next = overrun | bus.RX_Valid;
        if (bus.RdData_Valid) begin
          tx_data_next  = bus.RdData;
          tx_valid_next = 1'b1;
          state_next    = TX_SEND;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          // The wait has spanned TIMEOUT cycles with no data
          tx_data_next  = ERR_CODE;
          tx_valid_next = 1'b1;
          state_next    = TX_SEND;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      TX_SEND: begin
        overrun_next = overrun | bus.RX_Valid;
        if (bus.TX_Ready) begin
          tx_valid_next = 1'b0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
      addr     <= '0;
      wr_data  <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      wr_en    <= wr_en_next;
      rd_en    <= rd_en_next;
      addr     <= addr_next;
      wr_data  <= wr_data_next;
      tx_data  <= tx_data_next;
      tx_valid <= tx_valid_next;
      busy     <= busy_next;
      overrun  <= overrun_next;
    end
  end

  assign bus.WrEn     = wr_en;
  assign bus.RdEn     = rd_en;
  assign bus.Address  = addr;
  assign bus.WrData   = wr_data;
  assign bus.TX_Data  = tx_data;
  assign bus.TX_Valid = tx_valid;
  assign bus.Busy     = busy;
  assign bus.Overrun  = overrun;
endmodule
`default_nettype wire

// File: tb/tb_regfile_cmd_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_regfile_cmd_ctrl: vector table, corner sequences, random vs model   |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tb_regfile_cmd_ctrl;
  localparam int WIDTH   = 8;
  localparam int ADDRESS = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_cmd_ctrl_if #(.WIDTH(WIDTH), .ADDRESS(ADDRESS)) bus ();
  regfile_cmd_ctrl #(.WIDTH(WIDTH), .ADDRESS(ADDRESS), .TIMEOUT(TIMEOUT)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Output bundle: {WrEn, RdEn, Address, WrData, TX_Data, TX_Valid, Busy, Overrun}
  typedef logic [24:0] outs_t;

  // Reference model: a pending command byte, operand progress, read wait, response
  logic       m_wren, m_rden, m_txv, m_busy, m_ovr;
  logic [3:0] m_addr;
  logic [7:0] m_wdata, m_txd;
  int         m_cmd, m_nb, m_cnt;
  bit         m_wait;

  function automatic outs_t eo(bit we, bit re, logic [3:0] a, logic [7:0] wd,
                               logic [7:0] td, bit tv, bit b, bit ov);
    return {we, re, a, wd, td, tv, b, ov};
  endfunction

  function automatic outs_t dut_outs();
    return {bus.WrEn, bus.RdEn, bus.Address, bus.WrData, bus.TX_Data,
            bus.TX_Valid, bus.Busy, bus.Overrun};
  endfunction

  function automatic outs_t model_outs();
    return eo(m_wren, m_rden, m_addr, m_wdata, m_txd, m_txv, m_busy, m_ovr);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit rxv, input logic [7:0] rxd,
                            input bit rdv, input logic [7:0] rdd, input bit txr);
    if (r) begin
      {m_wren, m_rden, m_addr, m_wdata, m_txd, m_txv, m_busy, m_ovr} = '0;
      m_cmd = 0; m_nb = 0; m_cnt = 0; m_wait = 0;
      return;
    end
    m_wren = 1'b0;
    m_rden = 1'b0;
    if (m_txv) begin
      if (rxv) m_ovr = 1'b1;
      if (txr) m_txv = 1'b0;
    end else if (m_wait) begin
      if (rxv) m_ovr = 1'b1;
      if (rdv) begin
        m_txd = rdd; m_txv = 1'b1; m_wait = 0;
      end else if (m_cnt == TIMEOUT - 1) begin
        m_txd = 8'hEE; m_txv = 1'b1; m_wait = 0;
      end else begin
        m_cnt++;
      end
    end else if (rxv) begin
      if (m_cmd == 0) begin
        if (rxd == 8'hAA || rxd == 8'hBB) m_cmd = int'(rxd);
      end else if (m_nb == 0) begin
        if (int'(rxd) >= (1 << ADDRESS)) begin
          m_txd = 8'hEE; m_txv = 1'b1; m_cmd = 0;
        end else begin
          m_addr = rxd[3:0];
          if (m_cmd == 'hBB) begin
            m_rden = 1'b1; m_wait = 1; m_cnt = 0; m_cmd = 0;
          end else begin
            m_nb = 1;
          end
        end
      end else begin
        m_wdata = rxd; m_wren = 1'b1; m_cmd = 0; m_nb = 0;
      end
    end
    m_busy = (m_cmd != 0) || m_wait || m_txv;
  endtask

  // Drive one cycle of inputs, let the edge pass, advance the model
  task automatic cycle(input bit r, input bit rxv, input logic [7:0] rxd,
                       input bit rdv, input logic [7:0] rdd, input bit txr);
    rst = r; bus.RX_Valid = rxv; bus.RX_Data = rxd;
    bus.RdData_Valid = rdv; bus.RdData = rdd; bus.TX_Ready = txr;
    @(posedge clk);
    model_step(r, rxv, rxd, rdv, rdd, txr);
    #1;
  endtask

  task automatic step(input bit r, input bit rxv, input logic [7:0] rxd,
                      input bit rdv, input logic [7:0] rdd, input bit txr, input string name);
    cycle(r, rxv, rxd, rdv, rdd, txr);
    check(name, 32'(dut_outs()), 32'(model_outs()));
    check({name, "_excl"}, 32'(bus.WrEn & bus.RdEn), 32'd0);
    @(negedge clk);
  endtask

  typedef struct {
    bit r; bit rxv; logic [7:0] rxd; bit rdv; logic [7:0] rdd; bit txr; outs_t exp;
  } vec_t;
  vec_t vecs[20];

  function automatic vec_t mk(bit r, bit rxv, logic [7:0] rxd, bit rdv,
                              logic [7:0] rdd, bit txr, outs_t exp);
    vec_t v;
    v.r = r; v.rxv = rxv; v.rxd = rxd; v.rdv = rdv; v.rdd = rdd; v.txr = txr; v.exp = exp;
    return v;
  endfunction

  initial begin
    int n;
    bit rxv, rdv, txr, r;
    logic [7:0] rxd, rdd;

    rst = 1'b1;
    bus.RX_Valid = 1'b0; bus.RX_Data = '0; bus.RdData_Valid = 1'b0;
    bus.RdData = '0; bus.TX_Ready = 1'b0;

    // Write AA,03,5C; read BB,02 with a held response; aborted write; ignored 42
    vecs[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0, eo(0, 0, 4'h0, 8'h00, 8'h00, 0, 0, 0));
    vecs[1]  = mk(0, 1, 8'hAA, 0, 8'h00, 0, eo(0, 0, 4'h0, 8'h00, 8'h00, 0, 1, 0));
    vecs[2]  = mk(0, 1, 8'h03, 0, 8'h00, 0, eo(0, 0, 4'h3, 8'h00, 8'h00, 0, 1, 0));
    vecs[3]  = mk(0, 1, 8'h5C, 0, 8'h00, 0, eo(1, 0, 4'h3, 8'h5C, 8'h00, 0, 0, 0));
    vecs[4]  = mk(0, 0, 8'h00, 0, 8'h00, 0, eo(0, 0, 4'h3, 8'h5C, 8'h00, 0, 0, 0));
    vecs[5]  = mk(0, 1, 8'hBB, 0, 8'h00, 0, eo(0, 0, 4'h3, 8'h5C, 8'h00, 0, 1, 0));
    vecs[6]  = mk(0, 1, 8'h02, 0, 8'h00, 0, eo(0, 1, 4'h2, 8'h5C, 8'h00, 0, 1, 0));
    vecs[7]  = mk(0, 0, 8'h00, 0, 8'h00, 0, eo(0, 0, 4'h2, 8'h5C, 8'h00, 0, 1, 0));
    vecs[8]  = mk(0, 0, 8'h00, 1, 8'h81, 0, eo(0, 0, 4'h2, 8'h5C, 8'h81, 1, 1, 0));
    vecs[9]  = mk(0, 0, 8'h00, 0, 8'h00, 0, eo(0, 0, 4'h2, 8'h5C, 8'h81, 1, 1, 0));
    vecs[10] = mk(0, 0, 8'h00, 0, 8'h00, 0, eo(0, 0, 4'h2, 8'h5C, 8'h81, 1, 1, 0));
    vecs[11] = mk(0, 0, 8'h00, 0, 8'h00, 0, eo(0, 0, 4'h2, 8'h5C, 8'h81, 1, 1, 0));
    vecs[12] = mk(0, 0, 8'h00, 0, 8'h00, 1, eo(0, 0, 4'h2, 8'h5C, 8'h81, 0, 0, 0));
    vecs[13] = mk(0, 1, 8'hAA, 0, 8'h00, 0, eo(0, 0, 4'h2, 8'h5C, 8'h81, 0, 1, 0));
    vecs[14] = mk(0, 1, 8'h13, 0, 8'h00, 0, eo(0, 0, 4'h2, 8'h5C, 8'hEE, 1, 1, 0));
    vecs[15] = mk(0, 0, 8'h00, 0, 8'h00, 1, eo(0, 0, 4'h2, 8'h5C, 8'hEE, 0, 0, 0));
    vecs[16] = mk(0, 1, 8'hAA, 0, 8'h00, 0, eo(0, 0, 4'h2, 8'h5C, 8'hEE, 0, 1, 0));
    vecs[17] = mk(0, 1, 8'h07, 0, 8'h00, 0, eo(0, 0, 4'h7, 8'h5C, 8'hEE, 0, 1, 0));
    vecs[18] = mk(0, 1, 8'h11, 0, 8'h00, 0, eo(1, 0, 4'h7, 8'h11, 8'hEE, 0, 0, 0));
    vecs[19] = mk(0, 1, 8'h42, 0, 8'h00, 0, eo(0, 0, 4'h7, 8'h11, 8'hEE, 0, 0, 0));

    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].r, vecs[i].rxv, vecs[i].rxd, vecs[i].rdv, vecs[i].rdd, vecs[i].txr);
      check($sformatf("vec%0d", i), 32'(dut_outs()), 32'(vecs[i].exp));
      @(negedge clk);
    end

    // Read timeout: BB,05 and no read data
    step(1, 0, 8'h00, 0, 8'h00, 0, "to_reset");
    step(0, 1, 8'hBB, 0, 8'h00, 0, "to_cmd");
    step(0, 1, 8'h05, 0, 8'h00, 0, "to_addr");
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step(0, 0, 8'h00, 0, 8'h00, 0, "to_wait");
      if (bus.TX_Valid) begin
        n = i;
        break;
      end
    end
    check("timeout_cycles", 32'(n), 32'(TIMEOUT));
    check("timeout_data", 32'(bus.TX_Data), 32'hEE);

    // Byte arriving while the error response is held
    step(0, 1, 8'h33, 0, 8'h00, 0, "ovr_drop");
    check("ovr_flag", 32'(bus.Overrun), 32'd1);
    check("ovr_resp", 32'(bus.TX_Data), 32'hEE);
    step(0, 0, 8'h00, 0, 8'h00, 1, "ovr_accept");
    step(0, 1, 8'h42, 0, 8'h00, 0, "ignore_42");
    check("ignore_42_busy", 32'(bus.Busy), 32'd0);
    check("ovr_sticky", 32'(bus.Overrun), 32'd1);

    // Reset inside RD_WAIT, then a clean read
    step(0, 1, 8'hBB, 0, 8'h00, 0, "rw_cmd");
    step(0, 1, 8'h01, 0, 8'h00, 0, "rw_addr");
    step(0, 0, 8'h00, 0, 8'h00, 0, "rw_wait");
    step(1, 0, 8'h00, 1, 8'h99, 0, "rw_reset");
    check("rw_reset_zero", 32'(dut_outs()), 32'd0);
    step(0, 1, 8'hBB, 0, 8'h00, 0, "rw2_cmd");
    step(0, 1, 8'h01, 0, 8'h00, 0, "rw2_addr");
    step(0, 0, 8'h00, 1, 8'h5A, 0, "rw2_data");
    check("rw2_resp", 32'({bus.TX_Valid, bus.TX_Data}), 32'h15A);
    // Reset while the response is held
    step(1, 0, 8'h00, 0, 8'h00, 0, "tx_reset");
    check("tx_reset_zero", 32'(dut_outs()), 32'd0);
    step(0, 1, 8'hBB, 0, 8'h00, 0, "tx2_cmd");
    step(0, 1, 8'h01, 0, 8'h00, 0, "tx2_addr");
    step(0, 0, 8'h00, 1, 8'h3C, 0, "tx2_data");
    check("tx2_resp", 32'({bus.TX_Valid, bus.TX_Data}), 32'h13C);
    step(0, 0, 8'h00, 0, 8'h00, 1, "tx2_accept");

    // Random traffic against the model
    step(1, 0, 8'h00, 0, 8'h00, 0, "rnd_reset");
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      rxv = ($urandom_range(0, 9) < 4);
      case ($urandom_range(0, 3))
        0:       rxd = 8'hAA;
        1:       rxd = 8'hBB;
        2:       rxd = 8'($urandom_range(0, 15));
        default: rxd = 8'($urandom_range(0, 255));
      endcase
      rdv = ($urandom_range(0, 9) < 2);
      rdd = 8'($urandom_range(0, 255));
      txr = ($urandom_range(0, 1) == 1);
      step(r, rxv, rxd, rdv, rdd, txr, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
